ext_pipe: RTL

Pipelined, parametrised immediate extender for the decode stage of the multi-cycle/pipelined MIPS datapath. Accepts an immediate plus extension opcode over a valid/ready handshake. Returns the extended word one cycle later, through a 2-entry skid buffer, so upstream can stream without bubbles under downstream stall. Adds byte/halfword-scaled modes, an illegal-mode flag, a pass-through tag and a synchronous flush.

---
 rtl/ext_defs.sv | 25 ++
 rtl/ext_core.sv | 44 ++++
 rtl/ext_pipe.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ext_defs.sv
// ext_defs: shared encodings for the immediate extender.
//   EOp encodings for each extension mode, the illegal-mode boundary,
//   a helper that flags illegal modes, and the skid-buffer state type.
package ext_defs;

    localparam logic [2:0] EXT_SIGN   = 3'd0;
    localparam logic [2:0] EXT_ZERO   = 3'd1;
    localparam logic [2:0] EXT_LUI    = 3'd2;
    localparam logic [2:0] EXT_SL2    = 3'd3;
    localparam logic [2:0] EXT_SL1    = 3'd4;
    localparam logic [2:0] EXT_SB     = 3'd5;
    // Every encoding from here upward is illegal.
    localparam logic [2:0] EXT_ILL_LO = 3'd6;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    function automatic logic is_illegal_eop(input logic [2:0] op);
        return (op >= EXT_ILL_LO);
    endfunction

endpackage

// File: rtl/ext_core.sv
// ext_core: purely combinational immediate extender.
// Ports:
//   imm [IMM_W-1:0] in  : raw immediate
//   EOp [2:0]       in  : extension mode
//   ext [OUT_W-1:0] out : extended word (0 for illegal modes)
//   err             out : 1 when EOp is illegal
module ext_core
    import ext_defs::*;
#(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
) (
    input  logic [IMM_W-1:0] imm,
    input  logic [2:0]       EOp,
    output logic [OUT_W-1:0] ext,
    output logic             err
);

    logic [OUT_W-1:0] sext_s;
    logic [OUT_W-1:0] zext_s;
    logic [OUT_W-1:0] lui_s;
    logic [OUT_W-1:0] sb_s;

    assign sext_s = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign zext_s = {{(OUT_W-IMM_W){1'b0}}, imm};
    assign lui_s  = {imm, {(OUT_W-IMM_W){1'b0}}};
    assign sb_s   = {{(OUT_W-8){imm[7]}}, imm[7:0]};

    // Mode select; scaled modes shift the sign-extended word and drop the top bits.
    always_comb begin
        ext = {OUT_W{1'b0}};
        err = is_illegal_eop(EOp);
        case (EOp)
            EXT_SIGN: ext = sext_s;
            EXT_ZERO: ext = zext_s;
            EXT_LUI:  ext = lui_s;
            EXT_SL2:  ext = {sext_s[OUT_W-3:0], 2'b00};
            EXT_SL1:  ext = {sext_s[OUT_W-2:0], 1'b0};
            EXT_SB:   ext = sb_s;
            default:  ext = {OUT_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate extender with a 2-entry skid buffer.
// Ports:
//   clk, reset (sync, active-high), flush (sync, drops held entries)
//   in_valid/in_ready with imm, EOp, in_tag : upstream handshake
//   out_valid/out_ready with ext, out_tag, err : downstream handshake
// in_ready depends only on registered state, so there is no
// combinational path from out_ready back to in_ready.
module ext_pipe
    import ext_defs::*;
#(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] imm,
    input  logic [2:0]       EOp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             err
);

    pipe_state_e      state_r;
    pipe_state_e      state_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [OUT_W-1:0] head_ext_r;
    logic [TAG_W-1:0] head_tag_r;
    logic             head_err_r;
    logic [OUT_W-1:0] skid_ext_r;
    logic [TAG_W-1:0] skid_tag_r;
    logic             skid_err_r;
    logic [OUT_W-1:0] core_ext_s;
    logic             core_err_s;
    logic             acc_s;
    logic             deq_s;
    logic             load_head_new_s;
    logic             load_head_skid_s;
    logic             load_skid_s;

    ext_core #(
        .IMM_W (IMM_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm (imm),
        .EOp (EOp),
        .ext (core_ext_s),
        .err (core_err_s)
    );

    assign acc_s = in_valid && in_ready_r;
    assign deq_s = out_valid_r && out_ready;

    // Next-state and load-select logic; flush overrides any transfer-in.
    always_comb begin
        state_next_s     = state_r;
        load_head_new_s  = 1'b0;
        load_head_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        state_next_s    = ST_ONE;
                        load_head_new_s = 1'b1;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && deq_s) begin
                        load_head_new_s = 1'b1;
                    end else if (acc_s) begin
                        state_next_s = ST_TWO;
                        load_skid_s  = 1'b1;
                    end else if (deq_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (deq_s) begin
                        state_next_s     = ST_ONE;
                        load_head_skid_s = 1'b1;
                    end else begin
                        state_next_s = ST_TWO;
                    end
                end
                default: state_next_s = ST_EMPTY;
            endcase
        end
    end

    // State register plus handshake flags derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != ST_TWO);
            out_valid_r <= (state_next_s != ST_EMPTY);
        end
    end

    // Head and skid data registers; held whenever no load is selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ext_r <= {OUT_W{1'b0}};
            head_tag_r <= {TAG_W{1'b0}};
            head_err_r <= 1'b0;
            skid_ext_r <= {OUT_W{1'b0}};
            skid_tag_r <= {TAG_W{1'b0}};
            skid_err_r <= 1'b0;
        end else begin
            if (load_head_new_s) begin
                head_ext_r <= core_ext_s;
                head_tag_r <= in_tag;
                head_err_r <= core_err_s;
            end else if (load_head_skid_s) begin
                head_ext_r <= skid_ext_r;
                head_tag_r <= skid_tag_r;
                head_err_r <= skid_err_r;
            end else begin
                head_ext_r <= head_ext_r;
                head_tag_r <= head_tag_r;
                head_err_r <= head_err_r;
            end
            if (load_skid_s) begin
                skid_ext_r <= core_ext_s;
                skid_tag_r <= in_tag;
                skid_err_r <= core_err_s;
            end else begin
                skid_ext_r <= skid_ext_r;
                skid_tag_r <= skid_tag_r;
                skid_err_r <= skid_err_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign ext       = head_ext_r;
    assign out_tag   = head_tag_r;
    assign err       = head_err_r;

endmodule
